// File: rtl/dense_layer_sequencer_if.sv
// dense_layer_sequencer_if: neuron request/result link
// and the layer result stream.
interface dense_layer_sequencer_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int X_W         = 8,
  parameter int W_W         = 8,
  parameter int B_W         = 32,
  parameter int OUT_W       = 16,
  localparam int NID_W =
    (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) ();

  logic                      n_in_valid;
  logic                      n_in_ready;
  logic [NUM_INPUTS*X_W-1:0] n_x_flat;
  logic [NUM_INPUTS*W_W-1:0] n_w_flat;
  logic [B_W-1:0]            n_bias;
  logic [NUM_INPUTS-1:0]     n_mask_flat;
  logic [1:0]                n_act_sel;
  logic                      n_out_valid;
  logic [OUT_W-1:0]          n_out_data;

  logic                      res_valid;
  logic                      res_ready;
  logic [OUT_W-1:0]          res_data;
  logic [NID_W-1:0]          res_idx;
  logic                      res_last;

  modport master (
    output n_in_valid, n_x_flat, n_w_flat,
    output n_bias, n_mask_flat, n_act_sel,
    input  n_in_ready, n_out_valid, n_out_data,
    output res_valid, res_data, res_idx, res_last,
    input  res_ready
  );

  modport slave (
    input  n_in_valid, n_x_flat, n_w_flat,
    input  n_bias, n_mask_flat, n_act_sel,
    output n_in_ready, n_out_valid, n_out_data,
    input  res_valid, res_data, res_idx, res_last,
    output res_ready
  );

endinterface

// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: walks the neurons of one layer,
// fetching weights, issuing requests, streaming results.
module dense_layer_sequencer #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int X_W         = 8,
  parameter int W_W         = 8,
  parameter int B_W         = 32,
  parameter int OUT_W       = 16,
  localparam int NID_W =
    (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_INPUTS*X_W-1:0] x_flat,
  input  logic [NUM_INPUTS-1:0]     mask_flat,
  input  logic [1:0]                act_sel,
  output logic                      wmem_rd,
  output logic [NID_W-1:0]          wmem_addr,
  input  logic [NUM_INPUTS*W_W-1:0] wmem_w,
  input  logic [B_W-1:0]            wmem_b,
  dense_layer_sequencer_if.master   bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, ISSUE, COLLECT, EMIT
  } state_e;

  localparam logic [NID_W-1:0] LAST_K =
    NID_W'(NUM_NEURONS - 1);

  state_e state_q, state_d;

  logic [NID_W-1:0]          k_q;
  logic [NUM_INPUTS*X_W-1:0] x_q;
  logic [NUM_INPUTS-1:0]     mask_q;
  logic [1:0]                act_q;
  logic [NUM_INPUTS*W_W-1:0] w_q;
  logic [B_W-1:0]            b_q;
  logic [OUT_W-1:0]          rdata_q;
  logic [NID_W-1:0]          ridx_q;
  logic                      rlast_q;
  logic                      done_q;
  logic                      err_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = ISSUE;
      ISSUE:   if (bus.n_in_ready) state_d = COLLECT;
      COLLECT: if (bus.n_out_valid) state_d = EMIT;
      EMIT:    if (bus.res_ready)
                 state_d = rlast_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // layer latches, payload, result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      x_q     <= '0;
      mask_q  <= '0;
      act_q   <= '0;
      w_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      ridx_q  <= '0;
      rlast_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.n_out_valid && state_q != COLLECT)
        err_q <= 1'b1;
      if (state_q == IDLE && start) begin
        x_q    <= x_flat;
        mask_q <= mask_flat;
        act_q  <= act_sel;
        k_q    <= '0;
      end
      if (state_q == LOAD) begin
        w_q <= wmem_w;
        b_q <= wmem_b;
      end
      if (state_q == COLLECT && bus.n_out_valid) begin
        rdata_q <= bus.n_out_data;
        ridx_q  <= k_q;
        rlast_q <= (k_q == LAST_K);
      end
      if (state_q == EMIT && bus.res_ready) begin
        if (rlast_q) done_q <= 1'b1;
        else         k_q    <= k_q + 1'b1;
      end
    end
  end

  assign wmem_rd   = (state_q == FETCH);
  assign wmem_addr = k_q;

  assign bus.n_in_valid  = (state_q == ISSUE);
  assign bus.n_x_flat    = x_q;
  assign bus.n_w_flat    = w_q;
  assign bus.n_bias      = b_q;
  assign bus.n_mask_flat = mask_q;
  assign bus.n_act_sel   = act_q;

  assign bus.res_valid = (state_q == EMIT);
  assign bus.res_data  = rdata_q;
  assign bus.res_idx   = ridx_q;
  assign bus.res_last  = rlast_q;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb_dense_layer_sequencer: directed layers against a
// behavioural neuron and weight memory.
module tb_dense_layer_sequencer;

  localparam int NI = 8;
  localparam int NN = 4;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   x_flat = '0;
  logic [7:0]    mask_flat = '0;
  logic [1:0]    act_sel = '0;
  logic          wmem_rd;
  logic [NW-1:0] wmem_addr;
  logic [63:0]   wmem_w;
  logic [31:0]   wmem_b;
  logic          busy, done, err;

  logic rdy = 1'b1, rrdy = 1'b1, inj = 1'b0;
  logic nov;
  logic [15:0] nval;
  logic pend;
  int cnt;

  logic [63:0] wrow [NN];
  logic [31:0] brow [NN];
  logic [15:0] ev [NN];
  logic [15:0] got_d [8];
  logic [NW-1:0] got_i [8];
  logic got_l [8];
  int nres, hs, cyc;
  int n_chk = 0, n_err = 0;

  dense_layer_sequencer_if #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .X_W(8),
    .W_W(8), .B_W(32), .OUT_W(16)
  ) bus ();

  dense_layer_sequencer #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .X_W(8),
    .W_W(8), .B_W(32), .OUT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_flat(x_flat), .mask_flat(mask_flat),
    .act_sel(act_sel), .wmem_rd(wmem_rd),
    .wmem_addr(wmem_addr), .wmem_w(wmem_w),
    .wmem_b(wmem_b), .bus(bus), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign bus.n_in_ready  = rdy;
  assign bus.res_ready   = rrdy;
  assign bus.n_out_valid = nov | inj;
  assign bus.n_out_data  = nval;

  function automatic logic [15:0] neuron(
    input logic [63:0] x, input logic [63:0] w,
    input logic [31:0] b, input logic [7:0] m);
    logic signed [31:0] acc;
    logic signed [7:0] xa, wa;
    acc = b;
    for (int i = 0; i < NI; i++) begin
      xa = x[i*8 +: 8];
      wa = w[i*8 +: 8];
      if (m[i]) acc = acc + xa * wa;
    end
    return acc[15:0];
  endfunction

  always @(posedge clk) begin
    if (wmem_rd) begin
      wmem_w <= wrow[wmem_addr];
      wmem_b <= brow[wmem_addr];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nov  <= 1'b0;
      pend <= 1'b0;
      cnt  <= 0;
      nval <= '0;
    end else begin
      nov <= 1'b0;
      if (bus.n_in_valid && bus.n_in_ready) begin
        pend <= 1'b1;
        cnt  <= NI - 1;
        nval <= neuron(bus.n_x_flat, bus.n_w_flat,
                       bus.n_bias, bus.n_mask_flat);
      end else if (pend) begin
        if (cnt == 1) begin
          nov  <= 1'b1;
          pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, want);
    end
  endtask

  task automatic run_layer(input int bp, input int st,
                           input bit inj_on,
                           input bit sb_on);
    int ew, iw;
    bit injd;
    logic [15:0] hold_d;
    logic [63:0] hold_w;
    ew = 0; iw = 0; injd = 0;
    nres = 0; hs = 0;
    hold_d = '0; hold_w = '0;
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    while (cyc < 400) begin
      @(negedge clk);
      start = sb_on && (cyc == 20);
      inj = 1'b0;
      if (cyc == 1) begin
        x_flat = '1;
        mask_flat = '0;
      end
      if (done) break;
      if (bus.res_valid) begin
        if (ew == 0) hold_d = bus.res_data;
        else check("res_hold", bus.res_data, hold_d);
        if (inj_on && !injd) begin
          inj = 1'b1;
          injd = 1;
        end
        if (ew < bp) begin
          rrdy = 1'b0;
          ew++;
        end else begin
          rrdy = 1'b1;
          ew = 0;
          if (nres < 8) begin
            got_d[nres] = bus.res_data;
            got_i[nres] = bus.res_idx;
            got_l[nres] = bus.res_last;
          end
          nres++;
        end
      end else begin
        rrdy = 1'b1;
      end
      if (bus.n_in_valid || iw > 0) begin
        if (iw == 0) hold_w = bus.n_w_flat;
        else begin
          check("vld_hold", bus.n_in_valid, 1);
          check("pay_hold", bus.n_w_flat, hold_w);
        end
        if (iw < st) begin
          rdy = 1'b0;
          iw++;
        end else begin
          rdy = 1'b1;
          iw = 0;
          hs++;
        end
      end else begin
        rdy = 1'b1;
      end
      @(posedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    rrdy = 1'b1; rdy = 1'b1; start = 1'b0;
    for (int k = 0; k < NN; k++) begin
      check("res_data", got_d[k], ev[k]);
      check("res_idx", got_i[k], k);
      check("res_last", got_l[k], k == NN - 1);
    end
    check("n_res", nres, NN);
    check("n_hs", hs, NN);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    for (int k = 0; k < NN; k++) begin
      wrow[k] = '0;
      brow[k] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rvalid", bus.res_valid, 0);
    check("rst_nvalid", bus.n_in_valid, 0);
    check("rst_rd", wmem_rd, 0);
    check("rst_rdata", bus.res_data, 0);
    check("rst_addr", wmem_addr, 0);
    check("rst_wflat", bus.n_w_flat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    x_flat = {8{8'h10}};
    mask_flat = 8'hFF;
    for (int k = 0; k < NN; k++) begin
      wrow[k] = {8{8'h10}};
      brow[k] = '0;
      ev[k] = 16'h0800;
    end
    run_layer(0, 0, 0, 0);
    check("cyc_base", cyc, 49);

    x_flat = {8{8'h10}};
    mask_flat = 8'hFF;
    for (int k = 0; k < NN; k++) begin
      wrow[k] = '0;
      brow[k] = 32'(k) << 8;
      ev[k] = 16'(k) << 8;
    end
    run_layer(5, 0, 0, 0);
    check("cyc_bp", cyc, 69);

    for (int i = 0; i < NI; i++)
      x_flat[i*8 +: 8] = 8'(i + 1);
    mask_flat = 8'h0F;
    for (int k = 0; k < NN; k++) begin
      wrow[k] = {8{8'(k + 1)}};
      brow[k] = '0;
      ev[k] = 16'(10 * (k + 1));
    end
    run_layer(0, 3, 1, 1);
    check("cyc_stall", cyc, 61);
    check("err_set", err, 1);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    check("sb_no_layer", busy, 0);

    x_flat = {8{8'h10}};
    mask_flat = 8'hFF;
    for (int k = 0; k < NN; k++) begin
      wrow[k] = {8{8'h10}};
      brow[k] = '0;
      ev[k] = 16'h0800;
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_coll", bus.n_in_valid, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rvalid", bus.res_valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);

    x_flat = {8{8'h10}};
    mask_flat = 8'hFF;
    run_layer(0, 0, 0, 0);
    check("cyc_after_rst", cyc, 49);
    check("err_clear", err, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
